ssbcc_uart_tx: RTL

Outport-side UART transmitter peripheral for the 9x8 processor core. The processor writes bytes through an outport strobe into a small FIFO. The block serializes them as 8N1 frames on a single TX line. Busy, full and overflow status are returned on inport-readable signals.

---
 rtl/ssbcc_uart_pkg.sv | 16 +
 rtl/ssbcc_fifo.sv | 54 +++++
 rtl/ssbcc_uart_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ssbcc_uart_pkg.sv
// Shared constants and helpers for the ssbcc UART peripherals.
package ssbcc_uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int FRAME_BITS = 10;

  // Width of a counter that must hold 0..clk_per_bit-1; never narrower than 1 bit.
  function automatic int baud_cnt_width(input int clk_per_bit);
    return (clk_per_bit <= 2) ? 1 : $clog2(clk_per_bit);
  endfunction

endpackage

// File: rtl/ssbcc_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on o_data while non-empty.
// Pushes while full and pops while empty are ignored; fullness is judged on the pre-edge count.
module ssbcc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_data  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ssbcc_uart_tx.sv
// Outport UART transmitter: queues bytes in a FIFO and sends them as 8N1 frames on o_uart_tx.
// Back-to-back frames leave no idle gap; writes while full are dropped and latch o_ovf.
module ssbcc_uart_tx
  import ssbcc_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 10,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_ovf
);

  localparam int BW = baud_cnt_width(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          fifo_pop, fifo_empty, fifo_full;
  logic [7:0]    fifo_data;
  logic          baud_done;

  ssbcc_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr),
    .i_pop   (fifo_pop),
    .i_data  (i_wr_data),
    .o_data  (fifo_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_done ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    ovf_d    = ovf_q | (i_wr & fifo_full);

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      default: begin
        // End of stop bit: chain straight into the next start bit when more data is queued.
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != IDLE) | ~fifo_empty;
  assign o_full    = fifo_full;
  assign o_ovf     = ovf_q;

endmodule
